// File: rtl/spi_master.sv
// spi_master: SPI mode-0 (CPOL=0, CPHA=0, MSB-first) master.
//
// A start strobe in IDLE latches tx_data and runs one BITS-long transfer.
// sclk runs at clk/(2*CLK_DIV). miso is sampled on each rising sclk edge.
// The received word appears on rx_data with a one-cycle done pulse.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    transfer request, accepted only in IDLE
//   tx_data  word to send, sampled on the accepting edge
//   busy     high from the accepting edge until the done edge
//   done     one-cycle pulse, rx_data valid
//   rx_data  last received word
//   ss_n     active-low slave select (registered)
//   sclk     SPI clock, idles low (registered)
//   mosi     master data out (registered)
//   miso     slave data in (no synchronizer)
//
// state | meaning
// IDLE  | ss_n high, waiting for start
// LOW   | sclk low half-period; the last cycle raises sclk and samples miso
// HIGH  | sclk high half-period; the last cycle drops sclk and shifts mosi
// HOLD  | ss_n low hold after the last falling sclk, then done

module spi_master #(
    parameter int BITS    = 8,
    parameter int CLK_DIV = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] tx_data,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] rx_data,
    output logic            ss_n,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  div_cnt, div_next;
    logic [BIT_W-1:0]  bit_cnt, bit_next;
    logic [BITS-1:0]   tx_shift, tx_shift_next;
    logic [BITS-1:0]   rx_shift, rx_shift_next;
    logic [BITS-1:0]   rx_data_next;
    logic              ss_n_next, sclk_next, mosi_next, busy_next, done_next;
    logic              phase_last;

    assign phase_last = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        div_next      = div_cnt + DIV_W'(1);
        bit_next      = bit_cnt;
        tx_shift_next = tx_shift;
        rx_shift_next = rx_shift;
        rx_data_next  = rx_data;
        ss_n_next     = ss_n;
        sclk_next     = sclk;
        mosi_next     = mosi;
        busy_next     = busy;
        done_next     = 1'b0;

        unique case (state)
            IDLE: begin
                div_next = '0;
                if (start) begin
                    tx_shift_next = tx_data;
                    rx_shift_next = '0;
                    bit_next      = '0;
                    ss_n_next     = 1'b0;
                    mosi_next     = tx_data[BITS-1];
                    busy_next     = 1'b1;
                    state_next    = LOW;
                end
            end
            LOW: begin
                if (phase_last) begin
                    div_next      = '0;
                    sclk_next     = 1'b1;
                    rx_shift_next = {rx_shift[BITS-2:0], miso};
                    state_next    = HIGH;
                end
            end
            HIGH: begin
                if (phase_last) begin
                    div_next  = '0;
                    sclk_next = 1'b0;
                    if (bit_cnt == BIT_W'(BITS - 1)) begin
                        state_next = HOLD;
                    end else begin
                        // mosi takes the next bit on the falling edge, so it is
                        // stable for the whole low half before the next rise
                        tx_shift_next = tx_shift << 1;
                        mosi_next     = tx_shift[BITS-2];
                        bit_next      = bit_cnt + BIT_W'(1);
                        state_next    = LOW;
                    end
                end
            end
            HOLD: begin
                if (phase_last) begin
                    div_next     = '0;
                    ss_n_next    = 1'b1;
                    rx_data_next = rx_shift;
                    done_next    = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            bit_cnt  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            rx_data  <= '0;
            ss_n     <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            div_cnt  <= div_next;
            bit_cnt  <= bit_next;
            tx_shift <= tx_shift_next;
            rx_shift <= rx_shift_next;
            rx_data  <= rx_data_next;
            ss_n     <= ss_n_next;
            sclk     <= sclk_next;
            mosi     <= mosi_next;
            busy     <= busy_next;
            done     <= done_next;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: self-checking bench for spi_master.
// A default instance (BITS=8, CLK_DIV=4) talks to a behavioural mode-0
// slave; a second instance (BITS=16, CLK_DIV=2) runs in loopback.

module tb_spi_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy, done, ss_n, sclk, mosi;
    logic [7:0] rx_data;
    logic       miso = 1'b0;

    logic        start2 = 1'b0;
    logic [15:0] tx_data2 = 16'h0000;
    logic        busy2, done2, ss_n2, sclk2, mosi2, miso2;
    logic [15:0] rx_data2;

    always #5 clk = ~clk;

    spi_master dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
        .busy(busy), .done(done), .rx_data(rx_data),
        .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    assign miso2 = mosi2;

    spi_master #(.BITS(16), .CLK_DIV(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .tx_data(tx_data2),
        .busy(busy2), .done(done2), .rx_data(rx_data2),
        .ss_n(ss_n2), .sclk(sclk2), .mosi(mosi2), .miso(miso2)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural mode-0 slave, evaluated on the falling clk edge.
    logic [7:0] slave_data = 8'h00;
    logic [7:0] s_shift = 8'h00;
    logic [7:0] s_rx = 8'h00;
    int         rise_cnt = 0;
    int         stab_err = 0;
    logic       p_ss_n = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;

    always @(negedge clk) begin
        if (p_ss_n && !ss_n) begin
            s_shift = slave_data;
            miso = slave_data[7];
            s_rx = 8'h00;
            rise_cnt = 0;
            stab_err = 0;
        end
        if (!p_sclk && sclk) begin
            s_rx = {s_rx[6:0], mosi};
            rise_cnt = rise_cnt + 1;
            if (mosi !== p_mosi) stab_err = stab_err + 1;
        end
        if (p_sclk && !sclk) begin
            s_shift = s_shift << 1;
            miso = s_shift[7];
        end
        p_ss_n = ss_n;
        p_sclk = sclk;
        p_mosi = mosi;
    end

    // One transfer on the default instance; returns done latency from E0.
    task automatic do_transfer(input logic [7:0] tx, input logic [7:0] sd, output int lat);
        int e0;
        slave_data = sd;
        tx_data = tx;
        start = 1'b1;
        @(negedge clk);
        e0 = cyc;
        start = 1'b0;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                lat = cyc - e0;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] sd;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int lat;
        int d1, d2, ndone, e0;
        logic ok;

        vecs[0] = '{tx: 8'hA5, sd: 8'h3C};
        vecs[1] = '{tx: 8'h00, sd: 8'hFF};
        vecs[2] = '{tx: 8'hFF, sd: 8'h00};
        vecs[3] = '{tx: 8'h5A, sd: 8'hC3};
        vecs[4] = '{tx: 8'h01, sd: 8'h80};

        // Reset held 3 cycles with start high.
        start = 1'b1;
        tx_data = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        check("rst_ss_n", {31'd0, ss_n}, 32'd1);
        check("rst_sclk", {31'd0, sclk}, 32'd0);
        check("rst_mosi", {31'd0, mosi}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rx", {24'd0, rx_data}, 32'd0);
        start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ss_n", {31'd0, ss_n}, 32'd1);

        // Table-driven single transfers.
        for (int v = 0; v < 5; v++) begin
            do_transfer(vecs[v].tx, vecs[v].sd, lat);
            check("latency", lat, 32'd68);
            check("rx_data", {24'd0, rx_data}, {24'd0, vecs[v].sd});
            check("slave_rx", {24'd0, s_rx}, {24'd0, vecs[v].tx});
            check("rise_count", rise_cnt, 32'd8);
            check("mosi_stable", stab_err, 32'd0);
            @(negedge clk);
            check("done_pulse", {31'd0, done}, 32'd0);
            check("busy_clear", {31'd0, busy}, 32'd0);
            check("ss_n_idle", {31'd0, ss_n}, 32'd1);
            repeat (3) @(negedge clk);
        end

        // Back-to-back with start held high.
        slave_data = 8'h11;
        tx_data = 8'h81;
        start = 1'b1;
        @(negedge clk);
        d1 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin d1 = cyc; break; end
        end
        if (d1 < 0) check("b2b_done1_timeout", 32'd0, 32'd1);
        check("b2b_slave1", {24'd0, s_rx}, 32'h81);
        check("b2b_rx1", {24'd0, rx_data}, 32'h11);
        check("b2b_ss_n_high", {31'd0, ss_n}, 32'd1);
        tx_data = 8'h7E;
        slave_data = 8'h22;
        @(negedge clk);
        check("b2b_ss_n_low_again", {31'd0, ss_n}, 32'd0);
        check("b2b_busy_again", {31'd0, busy}, 32'd1);
        start = 1'b0;
        d2 = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin d2 = cyc; break; end
        end
        if (d2 < 0) check("b2b_done2_timeout", 32'd0, 32'd1);
        check("b2b_spacing", d2 - d1, 32'd69);
        check("b2b_slave2", {24'd0, s_rx}, 32'h7E);
        check("b2b_rx2", {24'd0, rx_data}, 32'h22);
        repeat (3) @(negedge clk);

        // Start pulsed while busy.
        slave_data = 8'h5A;
        tx_data = 8'h00;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rise_cnt == 5) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("busy_wait_bit4", {31'd0, ok}, 32'd1);
        tx_data = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (done) begin
                ndone = ndone + 1;
                check("busy_slave_rx", {24'd0, s_rx}, 32'h00);
                check("busy_rx_data", {24'd0, rx_data}, 32'h5A);
            end
        end
        check("busy_done_count", ndone, 32'd1);

        // Reset during HIGH of bit 3.
        slave_data = 8'hE7;
        tx_data = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rise_cnt == 4) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("mid_wait_bit3", {31'd0, ok}, 32'd1);
        check("mid_in_high", {31'd0, sclk}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_ss_n", {31'd0, ss_n}, 32'd1);
        check("mid_sclk", {31'd0, sclk}, 32'd0);
        check("mid_mosi", {31'd0, mosi}, 32'd0);
        check("mid_busy", {31'd0, busy}, 32'd0);
        check("mid_done", {31'd0, done}, 32'd0);
        check("mid_rx", {24'd0, rx_data}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) ndone = ndone + 1;
        end
        check("mid_no_done", ndone, 32'd0);
        do_transfer(8'hC3, 8'h96, lat);
        check("post_latency", lat, 32'd68);
        check("post_rx", {24'd0, rx_data}, 32'h96);
        check("post_slave_rx", {24'd0, s_rx}, 32'hC3);

        // Loopback, BITS=16, CLK_DIV=2.
        tx_data2 = 16'hBEEF;
        start2 = 1'b1;
        @(negedge clk);
        e0 = cyc;
        start2 = 1'b0;
        tx_data2 = 16'h0000;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done2) begin lat = cyc - e0; break; end
        end
        if (lat < 0) check("loop_timeout", 32'd0, 32'd1);
        check("loop_latency", lat, 32'd66);
        check("loop_rx", {16'd0, rx_data2}, 32'hBEEF);
        check("loop_ss_n", {31'd0, ss_n2}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
